// File: rtl/imm_narrow_unit_pkg.sv
// Shared definitions for the immediate narrowing unit: field-width selects and
// a helper that returns the field width N for a given select.
package imm_narrow_unit_pkg;

  typedef enum logic [1:0] {
    WSEL_16 = 2'b00,
    WSEL_22 = 2'b01,
    WSEL_28 = 2'b10,
    WSEL_32 = 2'b11
  } wsel_e;

  function automatic int unsigned wsel_width(input logic [1:0] wsel);
    case (wsel_e'(wsel))
      WSEL_16: return 16;
      WSEL_22: return 22;
      WSEL_28: return 28;
      default: return 32;
    endcase
  endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Combinational narrowing of a 32-bit signed value to an N-bit field plus range check.
// Optional macro IMM_NARROW_SAT_EN: clamp out-of-range results to the N-bit signed limit.
module imm_range_chk
  import imm_narrow_unit_pkg::*;
(
  input  logic [31:0] value_i,
  input  logic [1:0]  wsel_i,
  output logic [31:0] field_o,
  output logic        fits_o
);

  logic [4:0]         pad;
  logic [31:0]        mask;
  logic signed [31:0] sext;

  // Shift the field to the top and arithmetic-shift back: equal to the input
  // exactly when bits [31:N-1] all match, so N=32 (pad=0) always fits.
  always_comb begin
    pad     = 5'(32 - wsel_width(wsel_i));
    mask    = {32{1'b1}} >> pad;
    sext    = $signed(value_i << pad) >>> pad;
    fits_o  = (sext == $signed(value_i));
    field_o = value_i & mask;
`ifdef IMM_NARROW_SAT_EN
    if (!fits_o) begin
      field_o = value_i[31] ? ((mask >> 1) + 32'd1) : (mask >> 1);
    end
`endif
  end

endmodule

// File: rtl/imm_narrow_unit.sv
// Two-stage valid/ready pipeline narrowing signed values to 16/22/28/32-bit fields,
// with a saturating out-of-range counter. Optional macro IMM_NARROW_SAT_EN (see imm_range_chk).
module imm_narrow_unit
  import imm_narrow_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_wsel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_field,
  output logic             out_fits,
  output logic [1:0]       out_wsel,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_data_q, s1_data_d;
  logic [1:0]       s1_wsel_q, s1_wsel_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_field_q, s2_field_d;
  logic             s2_fits_q, s2_fits_d;
  logic [1:0]       s2_wsel_q, s2_wsel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] chk_field;
  logic        chk_fits;
  logic        s1_load, s2_load, out_hs;

  imm_range_chk u_chk (
    .value_i (s1_data_q),
    .wsel_i  (s1_wsel_q),
    .field_o (chk_field),
    .fits_o  (chk_fits)
  );

  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign out_hs   = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_wsel_d  = s1_wsel_q;
    s2_valid_d = s2_valid_q;
    s2_field_d = s2_field_q;
    s2_fits_d  = s2_fits_q;
    s2_wsel_d  = s2_wsel_q;
    cnt_d      = cnt_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_wsel_d  = in_wsel;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // Payload is only rewritten on load so it holds steady under backpressure.
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_field_d = chk_field;
      s2_fits_d  = chk_fits;
      s2_wsel_d  = s1_wsel_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    if (clr_count) begin
      cnt_d = '0;
    end else if (out_hs && !s2_fits_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_wsel_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_field_q <= '0;
      s2_fits_q  <= 1'b0;
      s2_wsel_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_wsel_q  <= s1_wsel_d;
      s2_valid_q <= s2_valid_d;
      s2_field_q <= s2_field_d;
      s2_fits_q  <= s2_fits_d;
      s2_wsel_q  <= s2_wsel_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_field = s2_field_q;
  assign out_fits  = s2_fits_q;
  assign out_wsel  = s2_wsel_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_imm_narrow_unit.sv
// Scoreboard bench for imm_narrow_unit (CNT_W=4); honours IMM_NARROW_SAT_EN in its model.
module tb_imm_narrow_unit;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic [1:0]       in_wsel = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_field;
  logic             out_fits;
  logic [1:0]       out_wsel;
  logic [CNT_W-1:0] ovf_count;
  logic             clr_count = 1'b0;

  imm_narrow_unit #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_wsel   (in_wsel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_fits  (out_fits),
    .out_wsel  (out_wsel),
    .ovf_count (ovf_count),
    .clr_count (clr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] field;
    logic        fits;
    logic [1:0]  wsel;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  int               n_checks = 0;
  int               n_fail = 0;
  int               n_acc = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             hold_v = 1'b0;
  logic [31:0]      hold_field = '0;
  logic             hold_fits = 1'b0;
  logic [1:0]       hold_wsel = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input logic [1:0] w);
    exp_t e;
    int   n;
    case (w)
      2'd0:    n = 16;
      2'd1:    n = 22;
      2'd2:    n = 28;
      default: n = 32;
    endcase
    e.wsel  = w;
    e.fits  = 1'b1;
    e.field = '0;
    for (int i = 0; i < n; i++) e.field[i] = d[i];
    for (int i = n; i < 32; i++) if (d[i] !== d[n-1]) e.fits = 1'b0;
`ifdef IMM_NARROW_SAT_EN
    if (!e.fits) begin
      e.field = '0;
      if (d[31]) e.field[n-1] = 1'b1;
      else for (int i = 0; i < n - 1; i++) e.field[i] = 1'b1;
    end
`endif
    return e;
  endfunction

  // Inputs only change just after posedge, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt = '0;
      hold_v  = 1'b0;
    end else begin
      check("ovf_count", 32'(ovf_count), 32'(exp_cnt));
      if (hold_v) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_field", out_field, hold_field);
        check("stall_fits", 32'(out_fits), 32'(hold_fits));
        check("stall_wsel", 32'(out_wsel), 32'(hold_wsel));
      end
      hold_v     = out_valid && !out_ready;
      hold_field = out_field;
      hold_fits  = out_fits;
      hold_wsel  = out_wsel;
      mon_e      = '{field: '0, fits: 1'b1, wsel: '0};
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", 32'(sb_q.size()), 32'd1);
        end else begin
          mon_e = sb_q.pop_front();
          check("out_field", out_field, mon_e.field);
          check("out_fits", 32'(out_fits), 32'(mon_e.fits));
          check("out_wsel", 32'(out_wsel), 32'(mon_e.wsel));
        end
      end
      if (clr_count) exp_cnt = '0;
      else if (out_valid && out_ready && !mon_e.fits && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      if (in_valid && in_ready) begin
        sb_q.push_back(model(in_data, in_wsel));
        n_acc++;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] w);
    logic        rdy;
    int unsigned t;
    t        = 0;
    rdy      = 1'b0;
    in_data  = d;
    in_wsel  = w;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 200);
    if (!rdy) check("send_timeout", 32'(rdy), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while ((sb_q.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] r, d;

    cycles(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_field", out_field, 32'd0);
    check("rst_out_fits", 32'(out_fits), 32'd0);
    check("rst_out_wsel", 32'(out_wsel), 32'd0);
    check("rst_ovf", 32'(ovf_count), 32'd0);
    rst_n = 1'b1;
    cycles(1);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed values, including the 2-cycle latency of the first word.
    send(32'h0000_7FFF, 2'b00);
    check("lat_pending", 32'(out_valid), 32'd0);
    cycles(1);
    check("lat_valid", 32'(out_valid), 32'd1);
    drain();
    check("ovf_first", 32'(ovf_count), 32'd0);
    send(32'hFFFF_8000, 2'b00);
    send(32'h0000_8000, 2'b00);
    drain();
    check("ovf_one", 32'(ovf_count), 32'd1);
    send(32'hF800_0000, 2'b10);
    send(32'h8000_0000, 2'b11);
    send(32'h001F_FFFF, 2'b01);
    send(32'h0020_0000, 2'b01);
    send(32'hFFE0_0000, 2'b01);
    send(32'hFFDF_FFFF, 2'b01);
    send(32'h07FF_FFFF, 2'b10);
    send(32'h0800_0000, 2'b10);
    send(32'h7FFF_FFFF, 2'b11);
    drain();

    // 8-word stream with the consumer stalled for 5 cycles.
    cycles(3);
    base = n_acc;
    fork
      for (int i = 0; i < 8; i++) send(32'h0001_0000 * i + 32'(i) + 32'hFFFF_FFF0 * (i % 2), 2'(i % 4));
      begin
        out_ready = 1'b0;
        cycles(5);
        check("stall_accepts", 32'(n_acc - base), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_accepts", 32'(n_acc - base), 32'd8);

    // Random words against a randomly toggling consumer.
    fork
      for (int i = 0; i < 40; i++) begin
        r = $urandom;
        case (i % 3)
          0:       d = r;
          1:       d = {{16{r[15]}}, r[15:0]};
          default: d = {{10{r[21]}}, r[21:0]};
        endcase
        send(d, 2'($urandom_range(0, 3)));
      end
      begin
        for (int i = 0; i < 60; i++) begin
          out_ready = 1'($urandom_range(0, 1));
          cycles(1);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Counter saturation, then clear coinciding with an overflow handshake.
    for (int i = 0; i < 20; i++) send(32'h0001_0000 + 32'(i), 2'b00);
    drain();
    check("ovf_sat", 32'(ovf_count), 32'hF);
    out_ready = 1'b0;
    send(32'h8000_0000, 2'b00);
    cycles(2);
    check("clr_pre_valid", 32'(out_valid), 32'd1);
    check("clr_pre_ovf", 32'(ovf_count), 32'hF);
    clr_count = 1'b1;
    out_ready = 1'b1;
    cycles(1);
    clr_count = 1'b0;
    check("ovf_clr", 32'(ovf_count), 32'd0);
    check("clr_sb_empty", 32'(sb_q.size()), 32'd0);
    send(32'h0002_0000, 2'b00);
    drain();
    check("ovf_after_clr", 32'(ovf_count), 32'd1);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(32'h0000_1111, 2'b00);
    send(32'h0000_2222, 2'b01);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_field", out_field, 32'd0);
    check("arst_ovf", 32'(ovf_count), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycles(1);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("no_stale", 32'(out_valid), 32'd0);
      cycles(1);
    end
    send(32'hFFFF_1234, 2'b00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
